axis_pixel_packer: RTL and testbench
====================================

# axis_pixel_packer

Downstream stage of the image-processing top: consumes the 8-bit filtered pixel stream from the output buffer's master side and packs four consecutive pixels into one 32-bit AXI-Stream word for the DMA S2MM channel. It generates `o_data_last` on the word holding the final pixel of each frame and pulses a frame-done flag. Full throughput: one pixel per cycle in, one word per four cycles out.

## Interface
- `FRAME_PIXELS`, 262144: pixels per frame. Must be a multiple of 4 and at least 4.
- `axi_clk` input 1: clock. All logic is rising-edge.
- `axi_reset_n` input 1: asynchronous, active-low reset.
- `i_data_valid` input 1: upstream pixel valid.
- `i_data` input 8: upstream pixel.
- `o_data_ready` output 1: ready to accept a pixel.
- `o_data_valid` output 1: packed word valid (AXIS tvalid).
- `o_data` output 32: packed word. Byte lane k (bits 8k+7:8k) holds pixel k of the group, so the first pixel sits in bits 7:0.
- `o_data_last` output 1: AXIS tlast. High on the word containing pixel `FRAME_PIXELS`-1.
- `i_data_ready` input 1: downstream ready (AXIS tready).
- `o_frame_done` output 1: one-cycle pulse when the last word of a frame handshakes.

## Operation
- Pixel accept: `i_data_valid && o_data_ready`. Word accept: `o_data_valid && i_data_ready`.
- `byte_cnt` (2 bits) selects the assembly lane.
  - On each pixel accept, write the pixel into assembly register lane `byte_cnt`, then increment `byte_cnt`. It wraps 3 to 0.
- When `byte_cnt`==3 and a pixel is accepted:
  - Transfer {pixel, asm[23:0]} to the output register `o_data`.
  - Set `o_data_valid`.
  - Set `o_data_last` = (`word_cnt` == `FRAME_PIXELS`/4 − 1).
  - If `o_data_last` is set, clear `word_cnt` to 0; otherwise increment it.
  - `word_cnt` width is $clog2(`FRAME_PIXELS`/4), minimum 1.
- Output register behaviour:
  - It holds its value and `o_data_valid` until a word accept.
  - On a word accept with no simultaneous load, clear `o_data_valid` and `o_data_last`.
  - On a simultaneous accept and load, the new word replaces the old one and `o_data_valid` stays 1.
- `o_data_ready` = `axi_reset_n` && !(`byte_cnt`==3 && `o_data_valid` && !`i_data_ready`).
  - This is a combinational path from `i_data_ready`, and it is intentional.
  - Lanes 0–2 always accept, even while the output is stalled.
- `o_frame_done` is registered. It is 1 in the cycle after a word accept in which `o_data_last` was 1.
- No data is dropped or duplicated under any valid/ready pattern.
  - AXIS rule: once asserted, `o_data_valid`, `o_data` and `o_data_last` are stable until accepted.
- Reset mid-frame: all state clears asynchronously. Any partially assembled word and any pending output word are discarded. The next accepted pixel is lane 0 of word 0 of a new frame.

## Timing
- Reset values:
  - `o_data_valid`=0, `o_data`=0, `o_data_last`=0, `o_frame_done`=0.
  - `o_data_ready`=0 while `axi_reset_n`=0.
  - Internally `byte_cnt`=0 and `word_cnt`=0; `o_data_ready` is 1 from the first cycle after release.
- Latency: the 4th pixel is accepted at edge N, and `o_data_valid`=1 with the packed word from edge N (visible in cycle N+1).
- `o_frame_done` is high for exactly one cycle, the cycle after the last-word accept.
- Back-to-back frames need no gap. Pixel 0 of frame n+1 may be accepted in the same cycle the last word of frame n is accepted.
- Throughput: with `i_data_ready` held at 1, `o_data_ready` never deasserts.

## Test plan
Bench uses `FRAME_PIXELS`=16.
- Reset release, `i_data_valid`=0 -> all outputs 0 during reset; `o_data_ready`=1 one cycle after release; no `o_data_valid`.
- Stream pixels 0x00..0x0F continuously, `i_data_ready`=1:
  - Words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, each valid one cycle after its 4th pixel.
  - `o_data_last` only on 0x0F0E0D0C.
  - `o_frame_done` pulses once.
  - `o_data_ready` stays 1.
- `i_data_ready`=0 while streaming 8 pixels:
  - First word 0x03020100 holds stable.
  - `o_data_ready` drops when the 8th pixel is presented.
  - Raise `i_data_ready` -> first word is accepted, 8th pixel accepted the same cycle, second word follows next cycle.
- Random `i_data_valid` and `i_data_ready` (50%), 3 frames of 0..47 mod 256 -> output bytes in order with no loss or duplication; exactly 3 tlasts, each on words 3, 7 and 11; 3 `o_frame_done` pulses.
- Assert reset after 6 pixels of a frame, then stream 0x10..0x1F -> first word 0x13121110; tlast on 0x1F1E1D1C; no residue from the aborted frame.
- Last word of frame 1 stalled while frame 2 pixels 0–2 arrive -> those pixels are accepted; frame 2 word 0 is correct; `o_frame_done` follows the frame 1 last-word accept by one cycle.

Source files
------------

// File: rtl/axis_pixel_packer.sv
// rtl/axis_pixel_packer.sv - packs four 8-bit pixels into one 32-bit AXI-Stream word
//
// Ports:
//   axi_clk, axi_reset_n          : clock, asynchronous active-low reset
//   i_data_valid, i_data[7:0]     : upstream pixel stream
//   o_data_ready                  : pixel accepted when i_data_valid && o_data_ready
//   o_data_valid, o_data[31:0]    : packed word, pixel k of the group in byte lane k
//   o_data_last                   : high on the word holding pixel FRAME_PIXELS-1
//   i_data_ready                  : downstream ready
//   o_frame_done                  : one-cycle pulse after the last word of a frame is accepted
module axis_pixel_packer #(
  parameter int FRAME_PIXELS = 262144
) (
  input  logic        axi_clk,
  input  logic        axi_reset_n,
  input  logic        i_data_valid,
  input  logic [7:0]  i_data,
  output logic        o_data_ready,
  output logic        o_data_valid,
  output logic [31:0] o_data,
  output logic        o_data_last,
  input  logic        i_data_ready,
  output logic        o_frame_done
);

  localparam int FRAME_WORDS = FRAME_PIXELS / 4;
  localparam int WCW         = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);

  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [23:0]    asm_q, asm_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [31:0]    data_q, data_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic           done_q, done_d;

  logic pix_acc;
  logic word_acc;
  logic load;

  // Lane 3 is the only pixel that needs the output register, so only it
  // waits for a stalled word; the reset term keeps ready low during reset.
  assign o_data_ready = axi_reset_n && !(byte_cnt_q == 2'd3 && valid_q && !i_data_ready);
  assign pix_acc      = i_data_valid && o_data_ready;
  assign word_acc     = valid_q && i_data_ready;
  assign load         = pix_acc && (byte_cnt_q == 2'd3);

  always_comb begin
    byte_cnt_d = byte_cnt_q + {1'b0, pix_acc};
    asm_d      = asm_q;
    word_cnt_d = word_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    done_d     = word_acc && last_q;

    if (pix_acc) begin
      case (byte_cnt_q)
        2'd0:    asm_d[7:0]   = i_data;
        2'd1:    asm_d[15:8]  = i_data;
        2'd2:    asm_d[23:16] = i_data;
        default: asm_d        = asm_q;
      endcase
    end

    // A load wins over a simultaneous accept: the new word replaces the old.
    if (load) begin
      data_d  = {i_data, asm_q};
      valid_d = 1'b1;
      last_d  = (word_cnt_q == LAST_WORD);
      if (word_cnt_q == LAST_WORD) begin
        word_cnt_d = '0;
      end else begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
    end else if (word_acc) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      byte_cnt_q <= 2'd0;
      asm_q      <= 24'd0;
      word_cnt_q <= '0;
      data_q     <= 32'd0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      word_cnt_q <= word_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  assign o_data_valid = valid_q;
  assign o_data       = data_q;
  assign o_data_last  = last_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_axis_pixel_packer.sv
// tb/tb_axis_pixel_packer.sv - directed self-checking bench for axis_pixel_packer
module tb_axis_pixel_packer;

  logic        clk;
  logic        rst_n;
  logic        i_data_valid;
  logic [7:0]  i_data;
  logic        o_data_ready;
  logic        o_data_valid;
  logic [31:0] o_data;
  logic        o_data_last;
  logic        i_data_ready;
  logic        o_frame_done;

  axis_pixel_packer #(.FRAME_PIXELS(16)) dut (
    .axi_clk      (clk),
    .axi_reset_n  (rst_n),
    .i_data_valid (i_data_valid),
    .i_data       (i_data),
    .o_data_ready (o_data_ready),
    .o_data_valid (o_data_valid),
    .o_data       (o_data),
    .o_data_last  (o_data_last),
    .i_data_ready (i_data_ready),
    .o_frame_done (o_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Output-side observer: accepted words, tlasts, done pulses, AXIS stability.
  logic [31:0] words[$];
  logic        lasts[$];
  int          done_cnt = 0;
  int          stab_err = 0;
  int          stall_cnt = 0;
  int          cyc = 0;
  int          last_acc_cyc = -10;
  int          done_cyc = -20;
  logic        hold = 1'b0;
  logic [31:0] hdata = 32'd0;
  logic        hlast = 1'b0;
  logic        rand_ready = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold && (o_data_valid !== 1'b1 || o_data !== hdata || o_data_last !== hlast))
        stab_err = stab_err + 1;
      hold  = o_data_valid && !i_data_ready;
      hdata = o_data;
      hlast = o_data_last;
      if (o_data_valid && i_data_ready) begin
        words.push_back(o_data);
        lasts.push_back(o_data_last);
        if (o_data_last) last_acc_cyc = cyc;
      end
      if (o_frame_done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 i_data_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic clear_obs();
    words.delete();
    lasts.delete();
    done_cnt  = 0;
    stab_err  = 0;
    stall_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    i_data_valid = 1'b0;
    i_data       = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 clear_obs();
  endtask

  // Presents one pixel and waits (bounded) until it is accepted.
  task automatic send(input logic [7:0] p, input bit rand_gap);
    int n;
    bit acc;
    if (rand_gap) begin
      n = 0;
      while ($urandom_range(0, 1) == 0 && n < 4) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    i_data_valid = 1'b1;
    i_data       = p;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = o_data_ready;
      if (!acc) stall_cnt++;
      @(posedge clk);
      #1;
      n++;
    end
    i_data_valid = 1'b0;
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout pixel %02h not accepted within 200 cycles", p);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    i_data_valid = 1'b0;
    i_data       = 8'd0;
    i_data_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (o_data_valid !== 1'b0) $display("FAIL rst_valid got %0h exp 0", o_data_valid); else passes++;
    checks++; if (o_data !== 32'd0) $display("FAIL rst_data got %08h exp 00000000", o_data); else passes++;
    checks++; if (o_data_last !== 1'b0) $display("FAIL rst_last got %0h exp 0", o_data_last); else passes++;
    checks++; if (o_frame_done !== 1'b0) $display("FAIL rst_done got %0h exp 0", o_frame_done); else passes++;
    checks++; if (o_data_ready !== 1'b0) $display("FAIL rst_ready got %0h exp 0", o_data_ready); else passes++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (o_data_ready !== 1'b1) $display("FAIL rel_ready got %0h exp 1", o_data_ready); else passes++;
    repeat (2) @(negedge clk);
    checks++; if (o_data_valid !== 1'b0) $display("FAIL rel_valid got %0h exp 0", o_data_valid); else passes++;
  endtask

  task automatic test_stream();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h03020100; exp_w[1] = 32'h07060504;
    exp_w[2] = 32'h0B0A0908; exp_w[3] = 32'h0F0E0D0C;
    do_reset();
    i_data_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0);
      if (i % 4 == 3) begin
        checks++; if (o_data_valid !== 1'b1) $display("FAIL str_valid word %0d got %0h exp 1", i / 4, o_data_valid); else passes++;
        checks++; if (o_data !== exp_w[i / 4]) $display("FAIL str_data word %0d got %08h exp %08h", i / 4, o_data, exp_w[i / 4]); else passes++;
        checks++; if (o_data_last !== (i == 15)) $display("FAIL str_last word %0d got %0h exp %0h", i / 4, o_data_last, (i == 15)); else passes++;
      end
    end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (words.size() != 4) $display("FAIL str_count got %0d exp 4", words.size()); else passes++;
    checks++; if (done_cnt != 1) $display("FAIL str_done_cnt got %0d exp 1", done_cnt); else passes++;
    checks++; if (done_cyc != last_acc_cyc + 1) $display("FAIL str_done_timing got %0d exp %0d", done_cyc, last_acc_cyc + 1); else passes++;
    checks++; if (stall_cnt != 0) $display("FAIL str_ready_drops got %0d exp 0", stall_cnt); else passes++;
  endtask

  task automatic test_stall();
    do_reset();
    i_data_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(8'(i), 1'b0);
    i_data_valid = 1'b1;
    i_data       = 8'h07;
    @(negedge clk);
    checks++; if (o_data_ready !== 1'b0) $display("FAIL stl_ready got %0h exp 0", o_data_ready); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (o_data_valid !== 1'b1 || o_data !== 32'h03020100) $display("FAIL stl_hold got v=%0h d=%08h exp v=1 d=03020100", o_data_valid, o_data); else passes++;
    @(posedge clk);
    #1 i_data_ready = 1'b1;
    @(negedge clk);
    checks++; if (o_data_ready !== 1'b1) $display("FAIL stl_ready_up got %0h exp 1", o_data_ready); else passes++;
    @(posedge clk);
    #1;
    i_data_valid = 1'b0;
    checks++; if (o_data_valid !== 1'b1 || o_data !== 32'h07060504) $display("FAIL stl_second got v=%0h d=%08h exp v=1 d=07060504", o_data_valid, o_data); else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (words.size() != 2) $display("FAIL stl_count got %0d exp 2", words.size()); else passes++;
    if (words.size() == 2) begin
      checks++; if (words[0] !== 32'h03020100 || words[1] !== 32'h07060504) $display("FAIL stl_words got %08h %08h exp 03020100 07060504", words[0], words[1]); else passes++;
    end
    checks++; if (stab_err != 0) $display("FAIL stl_stable got %0d exp 0", stab_err); else passes++;
  endtask

  task automatic test_random();
    int bad;
    logic [31:0] ew;
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 48; i++) send(8'(i), 1'b1);
    rand_ready = 1'b0;
    @(posedge clk);
    #2 i_data_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (words.size() != 12) $display("FAIL rnd_count got %0d exp 12", words.size()); else passes++;
    bad = 0;
    for (int w = 0; w < words.size() && w < 12; w++) begin
      ew = {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)};
      if (words[w] !== ew || lasts[w] !== (w % 4 == 3)) begin
        bad++;
        $display("FAIL rnd_word %0d got %08h last %0h exp %08h last %0h", w, words[w], lasts[w], ew, (w % 4 == 3));
      end
    end
    checks++; if (bad != 0) $display("FAIL rnd_words bad=%0d exp 0", bad); else passes++;
    checks++; if (done_cnt != 3) $display("FAIL rnd_done_cnt got %0d exp 3", done_cnt); else passes++;
    checks++; if (stab_err != 0) $display("FAIL rnd_stable got %0d exp 0", stab_err); else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_data_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (o_data_valid !== 1'b0 || o_data !== 32'd0) $display("FAIL mid_async got v=%0h d=%08h exp v=0 d=00000000", o_data_valid, o_data); else passes++;
    checks++; if (o_data_ready !== 1'b0) $display("FAIL mid_ready got %0h exp 0", o_data_ready); else passes++;
    do_reset();
    i_data_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (words.size() != 4) $display("FAIL mid_count got %0d exp 4", words.size()); else passes++;
    if (words.size() == 4) begin
      checks++; if (words[0] !== 32'h13121110) $display("FAIL mid_first got %08h exp 13121110", words[0]); else passes++;
      checks++; if (words[3] !== 32'h1F1E1D1C || lasts[3] !== 1'b1 || lasts[0] !== 1'b0) $display("FAIL mid_last got %08h l3=%0h l0=%0h exp 1F1E1D1C l3=1 l0=0", words[3], lasts[3], lasts[0]); else passes++;
    end
    checks++; if (done_cnt != 1) $display("FAIL mid_done_cnt got %0d exp 1", done_cnt); else passes++;
  endtask

  task automatic test_last_stall();
    do_reset();
    i_data_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    i_data_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'h20 + 8'(i), 1'b0);
    checks++; if (stall_cnt != 0) $display("FAIL lst_lane_stall got %0d exp 0", stall_cnt); else passes++;
    checks++; if (o_data_valid !== 1'b1 || o_data !== 32'h0F0E0D0C || o_data_last !== 1'b1) $display("FAIL lst_hold got v=%0h d=%08h l=%0h exp v=1 d=0F0E0D0C l=1", o_data_valid, o_data, o_data_last); else passes++;
    checks++; if (o_frame_done !== 1'b0 || done_cnt != 0) $display("FAIL lst_early_done got %0h cnt %0d exp 0", o_frame_done, done_cnt); else passes++;
    i_data_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (o_frame_done !== 1'b1 || o_data_valid !== 1'b0) $display("FAIL lst_done got done=%0h v=%0h exp done=1 v=0", o_frame_done, o_data_valid); else passes++;
    send(8'h23, 1'b0);
    checks++; if (o_frame_done !== 1'b0) $display("FAIL lst_done_width got %0h exp 0", o_frame_done); else passes++;
    checks++; if (o_data_valid !== 1'b1 || o_data !== 32'h23222120 || o_data_last !== 1'b0) $display("FAIL lst_f2w0 got v=%0h d=%08h l=%0h exp v=1 d=23222120 l=0", o_data_valid, o_data, o_data_last); else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (words.size() != 5) $display("FAIL lst_count got %0d exp 5", words.size()); else passes++;
    checks++; if (done_cyc != last_acc_cyc + 1 || done_cnt != 1) $display("FAIL lst_done_timing got cyc %0d cnt %0d exp cyc %0d cnt 1", done_cyc, done_cnt, last_acc_cyc + 1); else passes++;
  endtask

  initial begin
    rst_n        = 1'b0;
    i_data_valid = 1'b0;
    i_data       = 8'd0;
    i_data_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_random();
    test_reset_mid();
    test_last_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
